lsu_ctrl: RTL and testbench

Load/store control unit placed directly upstream of the DPI-backed data memory in the NPC core. It accepts one memory operation at a time from EXU over a valid/ready handshake and issues a single-cycle request to the memory. It waits a variable number of cycles for the memory response, then sign- or zero-extends load data and hands the result to WBU. It also detects misaligned and illegal accesses and bounds every wait with a timeout.

---
 rtl/lsu_ctrl_if.sv | 51 +++++
 rtl/lsu_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Handshake bundle between EXU, lsu_ctrl, the data memory and WBU.
// Modports:
//   master : the load/store unit view (accepts EXU ops, drives memory requests, drives WBU results)
//   slave  : the surrounding environment view (EXU, memory model and WBU combined)
// Signal groups:
//   in_*   EXU -> LSU operation with valid/ready handshake
//   mem_*  LSU <-> memory single-cycle request and variable-latency response
//   out_*  LSU -> WBU result with valid/ready handshake
interface lsu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_isLoad;
    logic        in_isStore;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;

    logic        mem_req;
    logic        mem_isLoad;
    logic        mem_isStore;
    logic [31:0] mem_addr;
    logic [31:0] mem_len;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic [1:0]  out_err;

    modport master (
        input  in_valid, in_isLoad, in_isStore, in_funct3, in_addr, in_wdata, in_rd,
        output in_ready,
        output mem_req, mem_isLoad, mem_isStore, mem_addr, mem_len, mem_wdata,
        input  mem_resp, mem_rdata,
        output out_valid, out_rdata, out_rd, out_err,
        input  out_ready
    );

    modport slave (
        output in_valid, in_isLoad, in_isStore, in_funct3, in_addr, in_wdata, in_rd,
        input  in_ready,
        input  mem_req, mem_isLoad, mem_isStore, mem_addr, mem_len, mem_wdata,
        output mem_resp, mem_rdata,
        input  out_valid, out_rdata, out_rd, out_err,
        output out_ready
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control unit sitting in front of the data memory.
// Accepts one operation at a time from EXU, issues a one-cycle memory request,
// waits (bounded by MEM_TIMEOUT) for the response, extends load data and
// presents the result to WBU. Misaligned/illegal ops complete without a request.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    lsu_ctrl_if.master (in_*, mem_*, out_* groups)
module lsu_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    lsu_ctrl_if.master bus
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned XLEN  = 32;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              op_load, op_load_d;
    logic [2:0]        op_funct3, op_funct3_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_isload_q, mem_isload_d;
    logic              mem_isstore_q, mem_isstore_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_len_q, mem_len_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_rdata_q, out_rdata_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic [1:0]        out_err_q, out_err_d;

    logic              is_mem;
    logic              illegal;
    logic              misaligned;

    // Byte count from the size field (funct3[1:0]).
    function automatic logic [XLEN-1:0] len_of(input logic [1:0] size);
        case (size)
            2'b00:   len_of = XLEN'(1);
            2'b01:   len_of = XLEN'(2);
            default: len_of = XLEN'(4);
        endcase
    endfunction

    // Store data with the bytes above the access size cleared.
    function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] d);
        case (size)
            2'b00:   store_data = {24'b0, d[7:0]};
            2'b01:   store_data = {16'b0, d[15:0]};
            default: store_data = d;
        endcase
    endfunction

    // Load data extension; memory returns the bytes in the low lanes.
    function automatic logic [XLEN-1:0] load_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            3'b000:  load_data = {{24{d[7]}}, d[7:0]};
            3'b001:  load_data = {{16{d[15]}}, d[15:0]};
            3'b100:  load_data = {24'b0, d[7:0]};
            3'b101:  load_data = {16'b0, d[15:0]};
            default: load_data = d;
        endcase
    endfunction

    // Classification of the operation currently offered by EXU.
    // Pass-through ALU results carry arbitrary funct3, so the size check only applies to memory ops.
    always_comb begin
        is_mem     = bus.in_isLoad | bus.in_isStore;
        illegal    = (bus.in_isLoad & bus.in_isStore)
                   | (is_mem & ((bus.in_funct3 == 3'b011) | (bus.in_funct3 == 3'b110) |
                                (bus.in_funct3 == 3'b111)))
                   | (bus.in_isStore & bus.in_funct3[2]);
        misaligned = ((bus.in_funct3[1:0] == 2'b01) & bus.in_addr[0])
                   | ((bus.in_funct3[1:0] == 2'b10) & (bus.in_addr[1:0] != 2'b00));
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            op_load       <= 1'b0;
            op_funct3     <= 3'b000;
            mem_req_q     <= 1'b0;
            mem_isload_q  <= 1'b0;
            mem_isstore_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_len_q     <= '0;
            mem_wdata_q   <= '0;
            out_valid_q   <= 1'b0;
            out_rdata_q   <= '0;
            out_rd_q      <= '0;
            out_err_q     <= ERR_OK;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            op_load       <= op_load_d;
            op_funct3     <= op_funct3_d;
            mem_req_q     <= mem_req_d;
            mem_isload_q  <= mem_isload_d;
            mem_isstore_q <= mem_isstore_d;
            mem_addr_q    <= mem_addr_d;
            mem_len_q     <= mem_len_d;
            mem_wdata_q   <= mem_wdata_d;
            out_valid_q   <= out_valid_d;
            out_rdata_q   <= out_rdata_d;
            out_rd_q      <= out_rd_d;
            out_err_q     <= out_err_d;
        end
    end

    // Next-state and next-output logic. Strobes are derived from the next state
    // so that they are registered and line up with the state they belong to.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        op_load_d     = op_load;
        op_funct3_d   = op_funct3;
        mem_isload_d  = 1'b0;
        mem_isstore_d = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_len_d     = mem_len_q;
        mem_wdata_d   = mem_wdata_q;
        out_rdata_d   = out_rdata_q;
        out_rd_d      = out_rd_q;
        out_err_d     = out_err_q;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    op_load_d   = bus.in_isLoad;
                    op_funct3_d = bus.in_funct3;
                    out_rd_d    = bus.in_rd;
                    if (illegal) begin
                        state_d     = DONE;
                        out_err_d   = ERR_ILLEGAL;
                        out_rdata_d = '0;
                    end else if (!is_mem) begin
                        state_d     = DONE;
                        out_err_d   = ERR_OK;
                        out_rdata_d = bus.in_addr;
                    end else if (misaligned) begin
                        state_d     = DONE;
                        out_err_d   = ERR_ALIGN;
                        out_rdata_d = '0;
                    end else begin
                        state_d       = REQ;
                        mem_isload_d  = bus.in_isLoad;
                        mem_isstore_d = bus.in_isStore;
                        mem_addr_d    = bus.in_addr;
                        mem_len_d     = len_of(bus.in_funct3[1:0]);
                        mem_wdata_d   = store_data(bus.in_funct3[1:0], bus.in_wdata);
                    end
                end
            end

            REQ: begin
                state_d = WAIT;
                cnt_d   = '0;
            end

            // A response on the timeout cycle still completes normally.
            WAIT: begin
                if (bus.mem_resp) begin
                    state_d     = DONE;
                    out_err_d   = ERR_OK;
                    out_rdata_d = op_load ? load_data(op_funct3, bus.mem_rdata) : '0;
                end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
                    state_d     = DONE;
                    out_err_d   = ERR_TIMEOUT;
                    out_rdata_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        mem_req_d   = (state_d == REQ);
        out_valid_d = (state_d == DONE);
    end

    // in_ready is a direct decode of the state register.
    assign bus.in_ready    = (state == IDLE);
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_isLoad  = mem_isload_q;
    assign bus.mem_isStore = mem_isstore_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_len     = mem_len_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rdata   = out_rdata_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_err     = out_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl (MEM_TIMEOUT = 4).
module tb_lsu_ctrl;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        bus.in_valid   = 1'b1;
        bus.in_isLoad  = ld;
        bus.in_isStore = st;
        bus.in_funct3  = f3;
        bus.in_addr    = addr;
        bus.in_wdata   = wdata;
        bus.in_rd      = rd;
    endtask

    // Accept in cycle 0, check the request in cycle 1, respond in cycle 2, check result in cycle 3.
    task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp_len,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_out);
        chk1({tag, ".in_ready_c0"}, bus.in_ready, 1'b1);
        drive(ld, st, f3, addr, wdata, rd);
        step();
        bus.in_valid = 1'b0;
        chk1({tag, ".mem_req_c1"}, bus.mem_req, 1'b1);
        chk1({tag, ".mem_isLoad"}, bus.mem_isLoad, ld);
        chk1({tag, ".mem_isStore"}, bus.mem_isStore, st);
        chk({tag, ".mem_addr"}, bus.mem_addr, addr);
        chk({tag, ".mem_len"}, bus.mem_len, exp_len);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, exp_wdata);
        chk1({tag, ".in_ready_c1"}, bus.in_ready, 1'b0);
        step();
        chk1({tag, ".mem_req_c2"}, bus.mem_req, 1'b0);
        chk1({tag, ".mem_isLoad_c2"}, bus.mem_isLoad, 1'b0);
        chk1({tag, ".mem_isStore_c2"}, bus.mem_isStore, 1'b0);
        chk({tag, ".mem_addr_c2"}, bus.mem_addr, addr);
        chk1({tag, ".out_valid_c2"}, bus.out_valid, 1'b0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'h0;
        chk1({tag, ".out_valid_c3"}, bus.out_valid, 1'b1);
        chk({tag, ".out_rdata"}, bus.out_rdata, exp_out);
        chk({tag, ".out_err"}, 32'(bus.out_err), 32'h0);
        chk({tag, ".out_rd"}, 32'(bus.out_rd), 32'(rd));
    endtask

    // Operation that completes without touching memory: out_valid in cycle 1.
    task automatic quick_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] exp_out, input logic [1:0] exp_err);
        drive(ld, st, f3, addr, 32'hFFFF_FFFF, rd);
        step();
        bus.in_valid = 1'b0;
        chk1({tag, ".out_valid_c1"}, bus.out_valid, 1'b1);
        chk1({tag, ".mem_req"}, bus.mem_req, 1'b0);
        chk({tag, ".out_rdata"}, bus.out_rdata, exp_out);
        chk({tag, ".out_err"}, 32'(bus.out_err), 32'(exp_err));
        chk({tag, ".out_rd"}, 32'(bus.out_rd), 32'(rd));
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk1({tag, ".out_valid_rel"}, bus.out_valid, 1'b0);
        chk1({tag, ".in_ready_rel"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clock       = 1'b0;
        reset       = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_isLoad  = 1'b0;
        bus.in_isStore = 1'b0;
        bus.in_funct3  = 3'b000;
        bus.in_addr    = 32'h0;
        bus.in_wdata   = 32'h0;
        bus.in_rd      = 5'd0;
        bus.mem_resp   = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.out_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        chk1("rst.in_ready", bus.in_ready, 1'b1);
        chk1("rst.out_valid", bus.out_valid, 1'b0);
        chk1("rst.mem_req", bus.mem_req, 1'b0);
        chk("rst.out_rdata", bus.out_rdata, 32'h0);
        chk("rst.out_err", 32'(bus.out_err), 32'h0);

        // Byte/half/word loads with sign and zero extension
        mem_op("lb", 1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd5, 32'h0000_00F0,
               32'd1, 32'h0, 32'hFFFF_FFF0);
        release_out("lb");
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 5'd6, 32'h0000_00F0,
               32'd1, 32'h0, 32'h0000_00F0);
        release_out("lbu");
        mem_op("lh", 1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd7, 32'h0000_8001,
               32'd2, 32'h0, 32'hFFFF_8001);
        release_out("lh");
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 5'd8, 32'h0000_8001,
               32'd2, 32'h0, 32'h0000_8001);
        release_out("lhu");
        mem_op("lw", 1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd9, 32'hCAFE_BABE,
               32'd4, 32'h0, 32'hCAFE_BABE);
        release_out("lw");

        // Stores: upper bytes of wdata cleared, result data forced to zero
        mem_op("sh", 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 5'd0, 32'h1234_5678,
               32'd2, 32'h0000_BEEF, 32'h0);
        release_out("sh");
        mem_op("sb", 1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1122_3344, 5'd0, 32'h1234_5678,
               32'd1, 32'h0000_0044, 32'h0);
        release_out("sb");
        mem_op("sw", 1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'h1122_3344, 5'd0, 32'h0,
               32'd4, 32'h1122_3344, 32'h0);
        release_out("sw");

        // No-request completions
        quick_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h8000_0006, 5'd10, 32'h0, 2'b01);
        release_out("lw_mis");
        quick_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h8000_0001, 5'd11, 32'h0, 2'b01);
        release_out("lh_mis");
        quick_op("pass", 1'b0, 1'b0, 3'b000, 32'h0000_1234, 5'd12, 32'h0000_1234, 2'b00);
        release_out("pass");
        quick_op("ill_both", 1'b1, 1'b1, 3'b010, 32'h8000_0000, 5'd13, 32'h0, 2'b11);
        release_out("ill_both");
        quick_op("ill_f3", 1'b1, 1'b0, 3'b011, 32'h8000_0000, 5'd14, 32'h0, 2'b11);
        release_out("ill_f3");
        quick_op("ill_sbu", 1'b0, 1'b1, 3'b100, 32'h8000_0000, 5'd15, 32'h0, 2'b11);
        release_out("ill_sbu");

        // Timeout: out_valid in cycle 2 + 4 + 1 = 7
        drive(1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0, 5'd16);
        step();
        bus.in_valid = 1'b0;
        chk1("to.mem_req_c1", bus.mem_req, 1'b1);
        for (int c = 2; c <= 6; c++) begin
            step();
            chk1($sformatf("to.out_valid_c%0d", c), bus.out_valid, 1'b0);
        end
        step();
        chk1("to.out_valid_c7", bus.out_valid, 1'b1);
        chk("to.out_err", 32'(bus.out_err), 32'h2);
        chk("to.out_rdata", bus.out_rdata, 32'h0);
        release_out("to");

        // Stray response while idle is ignored
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        step();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'h0;
        chk1("stray.in_ready", bus.in_ready, 1'b1);
        chk1("stray.out_valid", bus.out_valid, 1'b0);
        chk1("stray.mem_req", bus.mem_req, 1'b0);

        // Response on the timeout cycle wins
        drive(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd17);
        step();
        bus.in_valid = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            step();
            chk1($sformatf("race.out_valid_c%0d", c), bus.out_valid, 1'b0);
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_8001;
        step();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'h0;
        chk1("race.out_valid_c7", bus.out_valid, 1'b1);
        chk("race.out_err", 32'(bus.out_err), 32'h0);
        chk("race.out_rdata", bus.out_rdata, 32'hFFFF_8001);
        release_out("race");

        // WBU back-pressure: result held, no new acceptance
        mem_op("hold", 1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 5'd18, 32'h0000_007F,
               32'd1, 32'h0, 32'h0000_007F);
        drive(1'b0, 1'b0, 3'b000, 32'h0000_AAAA, 32'h0, 5'd19);
        for (int c = 0; c < 5; c++) begin
            step();
            chk1($sformatf("hold.out_valid_%0d", c), bus.out_valid, 1'b1);
            chk($sformatf("hold.out_rdata_%0d", c), bus.out_rdata, 32'h0000_007F);
            chk($sformatf("hold.out_rd_%0d", c), 32'(bus.out_rd), 32'd18);
            chk1($sformatf("hold.in_ready_%0d", c), bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
        release_out("hold");

        // Reset during WAIT drops the access
        drive(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 5'd20);
        step();
        bus.in_valid = 1'b0;
        step();
        chk1("rw.mem_req_c2", bus.mem_req, 1'b0);
        reset = 1'b1;
        #1;
        chk1("rw.out_valid_async", bus.out_valid, 1'b0);
        chk1("rw.mem_req_async", bus.mem_req, 1'b0);
        chk1("rw.in_ready_async", bus.in_ready, 1'b1);
        step();
        reset = 1'b0;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        step();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'h0;
        chk1("rw.in_ready_post", bus.in_ready, 1'b1);
        chk1("rw.out_valid_post", bus.out_valid, 1'b0);
        chk1("rw.mem_req_post", bus.mem_req, 1'b0);

        // Normal operation resumes after reset
        mem_op("post", 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd21, 32'h0BAD_F00D,
               32'd4, 32'h0, 32'h0BAD_F00D);
        release_out("post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
